// File: rtl/vec_csr_regfile_pkg.sv
// Shared definitions for the vector configuration CSR block: vtype field layout,
// vlmul/vsew encodings and the control FSM states.
package vec_csr_regfile_pkg;

    localparam int unsigned VlmulLsb    = 0;
    localparam int unsigned VsewLsb     = 3;
    localparam int unsigned VtaBit      = 6;
    localparam int unsigned VmaBit      = 7;
    localparam int unsigned VtypeResLsb = 8;

    typedef enum logic [2:0] {
        Lmul1    = 3'd0,
        Lmul2    = 3'd1,
        Lmul4    = 3'd2,
        Lmul8    = 3'd3,
        LmulRsvd = 3'd4,
        LmulF8   = 3'd5,
        LmulF4   = 3'd6,
        LmulF2   = 3'd7
    } vlmul_e;

    typedef enum logic [2:0] {
        Sew8  = 3'd0,
        Sew16 = 3'd1,
        Sew32 = 3'd2,
        Sew64 = 3'd3
    } vsew_e;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StResp
    } state_e;

endpackage

// File: rtl/vec_csr_regfile_if.sv
// Configuration request / response handshake bundle for vec_csr_regfile.
interface vec_csr_regfile_if #(
    parameter int unsigned XLEN = 32
);
    logic            cfg_valid;
    logic            cfg_ready;
    logic            csrwr_en;
    logic            vl_sel;
    logic            vtype_sel;
    logic            rs1rd_de;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      uimm;
    logic [10:0]     zimm;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;

    modport master (
        output cfg_valid, csrwr_en, vl_sel, vtype_sel, rs1rd_de, rs1_data, rs2_data,
               uimm, zimm, resp_ready,
        input  cfg_ready, resp_valid, resp_data
    );

    modport slave (
        input  cfg_valid, csrwr_en, vl_sel, vtype_sel, rs1rd_de, rs1_data, rs2_data,
               uimm, zimm, resp_ready,
        output cfg_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/vec_csr_regfile_vlmax_calc.sv
// Combinational VLMAX and vtype legality evaluation; VLMAX derived with shifts only.
module vec_vlmax_calc
    import vec_csr_regfile_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned VLEN = 512,
    parameter int unsigned ELEN = 64
) (
    input  logic [XLEN-1:0] vtype,
    output logic [XLEN-1:0] vlmax,
    output logic            illegal
);
    logic [2:0]      vlmul;
    logic [2:0]      vsew;
    logic [10:0]     sew;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] scaled;
    logic            unused_bits;

    assign unused_bits = ^{vtype[XLEN-1], vtype[VmaBit], vtype[VtaBit]};

    always_comb begin
        vlmul = vtype[VlmulLsb +: 3];
        vsew  = vtype[VsewLsb +: 3];
        sew   = 11'd8 << vsew;
        base  = XLEN'(VLEN) >> ({1'b0, vsew} + 4'd3);
        // Fractional LMUL 1/8, 1/4, 1/2 maps to right shifts of 3, 2, 1.
        if (vlmul[2]) begin
            scaled = base >> (3'd4 - {1'b0, vlmul[1:0]});
        end else begin
            scaled = base << vlmul[1:0];
        end
        illegal = (vlmul == LmulRsvd) || (vsew > Sew64) || (32'(sew) > ELEN) ||
                  (|vtype[XLEN-2:VtypeResLsb]) || (scaled == '0);
        vlmax   = illegal ? '0 : scaled;
    end
endmodule

// File: rtl/vec_csr_regfile.sv
// Vector configuration CSR file: executes vsetvl/vsetvli/vsetivli and holds vl/vtype.
module vec_csr_regfile
    import vec_csr_regfile_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned VLEN = 512,
    parameter int unsigned ELEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    vec_csr_regfile_if.slave bus,
    output logic [XLEN-1:0] vl,
    output logic [XLEN-1:0] vtype,
    output logic            vill,
    output logic [XLEN-1:0] vlmax
);
    state_e state_q, state_d;
    logic   accept;
    logic   commit;

    logic            op_vl_sel_q, op_vtype_sel_q, op_rs1rd_de_q;
    logic [XLEN-1:0] op_rs1_q, op_rs2_q;
    logic [4:0]      op_uimm_q;
    logic [10:0]     op_zimm_q;

    logic [XLEN-1:0] vl_q, vtype_q, vlmax_q, resp_data_q;
    logic            vill_q;

    logic [XLEN-1:0] new_vtype, avl, calc_vlmax, vl_d;
    logic            calc_illegal;

    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StCalc;
            StCalc:  state_d = StResp;
            StResp:  if (bus.resp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.cfg_ready  = (state_q == StIdle);
        bus.resp_valid = (state_q == StResp);
        bus.resp_data  = resp_data_q;
        accept         = (state_q == StIdle) && bus.cfg_valid && bus.csrwr_en;
        commit         = (state_q == StCalc);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_vl_sel_q    <= bus.vl_sel;
            op_vtype_sel_q <= bus.vtype_sel;
            op_rs1rd_de_q  <= bus.rs1rd_de;
            op_rs1_q       <= bus.rs1_data;
            op_rs2_q       <= bus.rs2_data;
            op_uimm_q      <= bus.uimm;
            op_zimm_q      <= bus.zimm;
        end
    end

    always_comb begin
        new_vtype = op_vtype_sel_q ? XLEN'(op_zimm_q) : op_rs2_q;
        avl       = op_vl_sel_q ? XLEN'(op_uimm_q) : op_rs1_q;
        if (calc_illegal)       vl_d = '0;
        else if (op_rs1rd_de_q) vl_d = (avl < calc_vlmax) ? avl : calc_vlmax;
        else                    vl_d = vl_q;
    end

    vec_vlmax_calc #(
        .XLEN(XLEN),
        .VLEN(VLEN),
        .ELEN(ELEN)
    ) u_vlmax_calc (
        .vtype  (new_vtype),
        .vlmax  (calc_vlmax),
        .illegal(calc_illegal)
    );

    // Reset wins over a same-cycle commit, so an aborted operation never lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            vl_q        <= '0;
            vtype_q     <= XLEN'(1) << (XLEN - 1);
            vill_q      <= 1'b1;
            vlmax_q     <= '0;
            resp_data_q <= '0;
        end else if (commit) begin
            vl_q        <= vl_d;
            vtype_q     <= calc_illegal ? (XLEN'(1) << (XLEN - 1)) : new_vtype;
            vill_q      <= calc_illegal;
            vlmax_q     <= calc_vlmax;
            resp_data_q <= vl_d;
        end
    end

    assign vl    = vl_q;
    assign vtype = vtype_q;
    assign vill  = vill_q;
    assign vlmax = vlmax_q;
endmodule
